// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for a word-wide data memory without byte enables; sub-word stores use read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses report resp_err instead of being force-aligned.
module lsu_mem_initiator #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_read_data,
    input  logic              mem_ack
);

    // state | meaning
    // IDLE  | ready for a new access
    // RD    | read strobe held until ack (load, or first half of RMW)
    // WR    | write strobe held until ack
    // DONE  | one-cycle response pulse
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t              state, state_nx;
    logic                st_q;
    logic [2:0]          f3_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         wdata_q;

    logic                req_illegal, req_misal, req_err;
    logic [ADDR_W-1:0]   req_addr_al;
    logic [31:0]         lane_word, load_data, merge_data;

    always_comb begin
        req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        req_addr_al = req_addr;
        req_misal   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        if (req_funct3[1:0] == 2'b01)
            req_addr_al[0] = 1'b0;
        else if (req_funct3[1:0] == 2'b10)
            req_addr_al[1:0] = 2'b00;
`endif
        req_err = req_illegal || req_misal;
    end

    // Word index kept as its own field; bits above it pass through untouched.
    assign mem_addr = {addr_q[ADDR_W-1:IDX_W+2], addr_q[IDX_W+1:2], 2'b00};

    always_comb begin
        lane_word = mem_read_data >> {addr_q[1:0], 3'b000};
        case (f3_q)
            3'b000:  load_data = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b001:  load_data = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b100:  load_data = {24'd0, lane_word[7:0]};
            3'b101:  load_data = {16'd0, lane_word[15:0]};
            default: load_data = mem_read_data;
        endcase
    end

    always_comb begin
        merge_data = mem_read_data;
        if (f3_q[1:0] == 2'b00)
            merge_data[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merge_data[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)
                        state_nx = S_DONE;
                    else if (req_store && (req_funct3[1:0] == 2'b10))
                        state_nx = S_WR;
                    else
                        state_nx = S_RD;
                end
            end
            S_RD: begin
                mem_read = 1'b1;
                if (mem_ack)
                    state_nx = st_q ? S_WR : S_DONE;
            end
            S_WR: begin
                mem_write = 1'b1;
                if (mem_ack)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                resp_valid = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q           <= 1'b0;
            f3_q           <= 3'b000;
            addr_q         <= '0;
            wdata_q        <= 16'd0;
            mem_write_data <= 32'd0;
            resp_rdata     <= 32'd0;
            resp_err       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        st_q    <= req_store;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr_al;
                        wdata_q <= req_wdata[15:0];
                        if (req_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_store && (req_funct3[1:0] == 2'b10)) begin
                            mem_write_data <= req_wdata;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        if (st_q) begin
                            mem_write_data <= merge_data;
                        end else begin
                            resp_rdata <= load_data;
                            resp_err   <= 1'b0;
                        end
                    end
                end
                S_WR: begin
                    if (mem_ack) begin
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: directed cases, reset abort, then random accesses against a byte-level memory model.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_read, mem_write, mem_ack;

    int total = 0;
    int bad   = 0;

    logic [31:0] tb_mem  [0:1023];
    logic [31:0] ref_mem [0:1023];

    always #5 clk = ~clk;

    lsu_mem_initiator #(.ADDR_W(32), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data), .mem_ack(mem_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        w = ref_mem[a[11:2]];
        w = w >> (8 * a[1:0]);
        return w[7:0];
    endfunction

    task automatic ref_put(input logic [31:0] a, input logic [7:0] b);
        logic [31:0] w;
        int sh;
        sh = 8 * a[1:0];
        w  = ref_mem[a[11:2]];
        w  = (w & ~(32'h0000_00FF << sh)) | ({24'd0, b} << sh);
        ref_mem[a[11:2]] = w;
    endtask

    // Issues one access, plays a responder with the given wait counts and checks against the model.
    task automatic do_access(input string name, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input int rd_wait, input int wr_wait,
                             output logic [31:0] got_rdata, output logic got_err);
        int n, exp_nr, exp_nw, exp_lat, cyc, cnt, nr, nw;
        bit legal, sgn, err, done, addr_ok, both_hi;
        logic [31:0] ea, exp_rd, exp_maddr, tmp;
        longint v, one;

        legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        n     = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        sgn   = !f3[2];
`ifdef LSU_MISALIGN_TRAP_EN
        ea  = a;
        err = !legal || ((a % 32'(n)) != 0);
`else
        ea  = a - (a % 32'(n));
        err = !legal;
`endif
        exp_rd = 32'd0; exp_nr = 0; exp_nw = 0; exp_lat = 1;
        one = 1;
        if (!err) begin
            if (!st) begin
                v = 0;
                for (int i = 0; i < n; i++)
                    v += longint'(ref_byte(ea + 32'(i))) << (8 * i);
                if (sgn && v >= (one << (8 * n - 1)))
                    v -= (one << (8 * n));
                exp_rd  = v[31:0];
                exp_nr  = 1;
                exp_lat = 2 + rd_wait;
            end else begin
                for (int i = 0; i < n; i++) begin
                    tmp = wd >> (8 * i);
                    ref_put(ea + 32'(i), tmp[7:0]);
                end
                exp_nw  = 1;
                exp_nr  = (n < 4) ? 1 : 0;
                exp_lat = (n < 4) ? 3 + rd_wait + wr_wait : 2 + wr_wait;
            end
        end
        exp_maddr = {ea[31:2], 2'b00};

        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        mem_ack    = 1'($urandom % 2);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_store  = 1'($urandom % 2);
        req_funct3 = 3'($urandom % 8);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        mem_ack    = 1'b0;

        cyc = 1; cnt = 0; nr = 0; nw = 0;
        done = 0; addr_ok = 1; both_hi = 0;
        got_rdata = 32'd0; got_err = 1'b0;
        while (!done && cyc < 60) begin
            if (mem_read && mem_write) both_hi = 1;
            mem_ack       = 1'b0;
            mem_read_data = $urandom;
            if (resp_valid) begin
                got_rdata = resp_rdata;
                got_err   = resp_err;
                done      = 1;
                mem_ack   = 1'($urandom % 2);
            end else if (mem_read || mem_write) begin
                if (mem_addr != exp_maddr) addr_ok = 0;
                if (cnt == (mem_read ? rd_wait : wr_wait)) begin
                    mem_ack = 1'b1;
                    cnt     = 0;
                    if (mem_read) begin
                        mem_read_data = tb_mem[mem_addr[11:2]];
                        nr++;
                    end else begin
                        tb_mem[mem_addr[11:2]] = mem_write_data;
                        nw++;
                    end
                end else begin
                    cnt++;
                end
            end
            if (!done) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end

        if (!done) begin
            check({name, ".timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, ".rdata"}, got_rdata, exp_rd);
            check({name, ".err"}, 32'(got_err), 32'(err));
            check({name, ".latency"}, 32'(cyc), 32'(exp_lat));
            check({name, ".reads"}, 32'(nr), 32'(exp_nr));
            check({name, ".writes"}, 32'(nw), 32'(exp_nw));
            check({name, ".mem_addr_ok"}, 32'(addr_ok), 32'd1);
            check({name, ".strobe_overlap"}, 32'(both_hi), 32'd0);
            if (st && !err)
                check({name, ".mem_word"}, tb_mem[ea[11:2]], ref_mem[ea[11:2]]);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check({name, ".pulse_end"}, 32'(resp_valid), 32'd0);
        check({name, ".ready_again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        bit          seen;
        logic        rs;
        logic [2:0]  rf;
        logic [31:0] ra;

        rst_n = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0;
        mem_ack = 1'b0; mem_read_data = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[16]  = 32'h8899_AABB;
        ref_mem[16] = 32'h8899_AABB;

        #2;
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.resp_err", 32'(resp_err), 32'd0);
        check("reset.resp_rdata", resp_rdata, 32'd0);
        check("reset.mem_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("reset.mem_addr", mem_addr, 32'd0);
        check("reset.mem_write_data", mem_write_data, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_access("lw40", 1'b0, 3'b010, 32'h40, 32'd0, 0, 0, r, e);
        check("plan.lw40", r, 32'h8899_AABB);
        do_access("lb43", 1'b0, 3'b000, 32'h43, 32'd0, 0, 0, r, e);
        check("plan.lb43", r, 32'hFFFF_FF88);
        do_access("lbu43", 1'b0, 3'b100, 32'h43, 32'd0, 0, 0, r, e);
        check("plan.lbu43", r, 32'h0000_0088);
        do_access("lhu42", 1'b0, 3'b101, 32'h42, 32'd0, 0, 0, r, e);
        check("plan.lhu42", r, 32'h0000_8899);
        do_access("lh41", 1'b0, 3'b001, 32'h41, 32'd0, 0, 0, r, e);
`ifdef LSU_MISALIGN_TRAP_EN
        check("plan.lh41_err", 32'(e), 32'd1);
`else
        check("plan.lh41", r, 32'hFFFF_AABB);
`endif
        do_access("sb41", 1'b1, 3'b000, 32'h41, 32'h0000_0055, 2, 2, r, e);
        check("plan.sb41_word", tb_mem[16], 32'h8899_55BB);
        do_access("sw80", 1'b1, 3'b010, 32'h80, 32'h1234_5678, 0, 0, r, e);
        check("plan.sw80_word", tb_mem[32], 32'h1234_5678);

        // Abort an in-flight read with reset.
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h44;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rst.rd_active", 32'(mem_read), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst.read_dropped", 32'(mem_read), 32'd0);
        check("rst.no_write", 32'(mem_write), 32'd0);
        check("rst.ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (resp_valid || mem_read || mem_write) seen = 1;
        end
        check("rst.quiet_after", 32'(seen), 32'd0);
        check("rst.ready_after", 32'(req_ready), 32'd1);
        do_access("illegal011", 1'b0, 3'b011, 32'h48, 32'd0, 0, 0, r, e);
        check("plan.illegal_err", 32'(e), 32'd1);

        for (int k = 0; k < 200; k++) begin
            rs = 1'($urandom % 2);
            rf = 3'($urandom % 8);
            ra = $urandom;
            ra[11:6] = 6'd0;
            do_access($sformatf("rnd%0d", k), rs, rf, ra, $urandom,
                      int'($urandom % 4), int'($urandom % 4), r, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit: the initiator side of the word-wide data-memory interface. The data memory is the responder.
- Takes one load or store from the core's execute stage and issues the memory transactions.
- Byte and halfword stores use read-modify-write, because the memory has no byte enables.
- Sub-word loads are sign- or zero-extended. The core stalls on `req_ready` while an access is in flight.

Parameters:
- ADDR_W, 32, width of the byte address on the core side and the memory side
- MEM_WORDS, 1024, memory depth in 32-bit words; the word index is `addr[log2(MEM_WORDS)+1:2]`

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  core presents an access
- req_ready  output  1  LSU can accept an access (IDLE only)
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data (low bits used for B/H)
- resp_valid  output  1  one-cycle pulse: access complete
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  misaligned or illegal funct3; valid with resp_valid
- mem_addr  output  ADDR_W  word-aligned address (low 2 bits always 0)
- mem_write_data  output  32  full word to write
- mem_read  output  1  read strobe, held until mem_ack
- mem_write  output  1  write strobe, held until mem_ack
- mem_read_data  input  32  read word, valid when mem_ack and mem_read
- mem_ack  input  1  responder completes the current strobe this cycle

Behaviour:
- Reset values (asynchronous, immediate): state IDLE; `req_ready`=1; `resp_valid`=0; `resp_err`=0; `resp_rdata`=0; `mem_read`=0; `mem_write`=0; `mem_addr`=0; `mem_write_data`=0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch store, funct3, addr and wdata.
  - Error (see Optional Feature) -> DONE with err set.
  - SW -> WR, with `mem_write_data`=`req_wdata`.
  - Any load, SB or SH -> RD.
- RD:
  - `mem_read`=1 and `mem_addr`={addr[ADDR_W-1:2],2'b00}.
  - Without mem_ack: stay.
  - On mem_ack, load: select the byte/half by addr[1:0], extend per funct3, register into `resp_rdata`, go DONE.
  - On mem_ack, SB/SH: merge the new byte/half into the read word at lane addr[1:0] into `mem_write_data`, go WR.
- WR:
  - `mem_write`=1 and `mem_addr` as in RD.
  - On mem_ack -> DONE.
- DONE:
  - `resp_valid`=1 for exactly one cycle, `req_ready`=0.
  - Next state is IDLE.
  - resp_* hold their values until the next DONE. resp_rdata=0 for stores.
- `mem_read` and `mem_write` are never high together. Strobes drop in the cycle after the ack.
- `mem_ack` outside RD/WR is ignored.
- Latency with a zero-wait responder (mem_ack same cycle as strobe), counted from the accept cycle (cycle 0):
  - load / SW: resp_valid at cycle 2
  - SB/SH: resp_valid at cycle 3
- Each wait cycle adds one cycle.
- Illegal funct3 (011, 110, 111): resp_err=1, no memory access.
- Lane select: B lanes 0..3 = bits [7:0]..[31:24]; H lane 0 = [15:0], lane 2 = [31:16].
- Address bits above the word index are passed through unchanged.
- rst_n low mid-RD or mid-WR: strobes drop immediately. The access is abandoned, with no resp_valid and no partial write after reset. The responder must tolerate the dropped strobe.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN
- Defined: H with addr[0]=1, or W with addr[1:0]!=0, goes IDLE->DONE with resp_err=1 and resp_rdata=0. No mem strobe is issued.
- Undefined: misaligned addresses are silently forced to natural alignment (H clears bit 0; W clears bits 1:0), the access proceeds normally, and resp_err reflects only illegal funct3.

Test Plan:
- Memory word 0x40 = 0x8899AABB. LW at 0x40, zero-wait -> mem_read for 1 cycle, resp_valid at cycle 2, rdata=0x8899AABB, err=0.
- Same word, LB at 0x43 -> rdata=0xFFFFFF88. LBU at 0x43 -> 0x00000088. LHU at 0x42 -> 0x00008899.
- SB 0x55 to 0x41 with mem_ack delayed 2 cycles on each strobe -> read then write, mem_write_data=0x8899557B... corrected: 0x889955BB. resp_valid at cycle 7, rdata=0.
- SW 0x12345678 to 0x80 -> no mem_read, one mem_write with data 0x12345678, resp_valid at cycle 2.
- LH at 0x41:
  - With LSU_MISALIGN_TRAP_EN: no strobes, resp_err=1 at cycle 1.
  - Without it: read of 0x40, rdata=0xFFFFAABB, err=0.
- rst_n asserted while in RD waiting for ack -> mem_read=0 immediately. After release: IDLE, req_ready=1, no resp_valid. Illegal funct3 011 afterwards -> resp_err=1, no strobes.
